// File: rtl/calc_sequencer_if.sv
// Calculator memory port and run enable between the job sequencer and the processor.
// The sequencer is the master and the only driver of address, data, strobe and run enable.
interface calc_sequencer_if;
    logic        cpu_run;
    logic [31:0] EntradaCalcu;
    logic [31:0] addressCalcu;
    logic        writeEnableCalcu;
    logic [31:0] resultadoCalcu;

    modport master (
        output cpu_run,
        output EntradaCalcu,
        output addressCalcu,
        output writeEnableCalcu,
        input  resultadoCalcu
    );

    modport slave (
        input  cpu_run,
        input  EntradaCalcu,
        input  addressCalcu,
        input  writeEnableCalcu,
        output resultadoCalcu
    );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator job sequencer: loads operands into data memory, runs the processor,
// polls the status word until completion or timeout and returns the result to the host.
//
// state  | meaning
// IDLE   | waiting for start, port quiet
// WR_A   | writing operand A
// WR_B   | writing operand B
// WR_OP  | writing zero-extended opcode
// CLR_ST | clearing status word, run counter reset
// P_ADDR | processor running, status address presented
// P_CHK  | processor running, status word sampled
// R_ADDR | processor running, result address presented
// R_CHK  | processor running, result word sampled
// DONE   | completion pulse, success
// ERR    | completion pulse, timeout
module calc_sequencer #(
    parameter logic [31:0] ADDR_A   = 32'h40,
    parameter logic [31:0] ADDR_B   = 32'h44,
    parameter logic [31:0] ADDR_OP  = 32'h48,
    parameter logic [31:0] ADDR_ST  = 32'h4C,
    parameter logic [31:0] ADDR_RES = 32'h50,
    parameter int          TIMEOUT  = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      operand_a,
    input  logic [31:0]      operand_b,
    input  logic [1:0]       opcode,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [31:0]      result,
    calc_sequencer_if.master mem
);

    typedef enum logic [3:0] {
        IDLE,
        WR_A,
        WR_B,
        WR_OP,
        CLR_ST,
        P_ADDR,
        P_CHK,
        R_ADDR,
        R_CHK,
        DONE,
        ERR
    } state_t;

    localparam logic [15:0] TIMEOUT_CNT = TIMEOUT[15:0];

    state_t      state;
    state_t      state_nxt;
    logic [31:0] b_q;
    logic [1:0]  op_q;
    logic [15:0] run_cnt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !abort) state_nxt = WR_A;
            WR_A:    state_nxt = WR_B;
            WR_B:    state_nxt = WR_OP;
            WR_OP:   state_nxt = CLR_ST;
            CLR_ST:  state_nxt = P_ADDR;
            P_ADDR:  state_nxt = P_CHK;
            P_CHK: begin
                if (mem.resultadoCalcu != 32'h0)
                    state_nxt = R_ADDR;
                else if (run_cnt >= TIMEOUT_CNT)
                    state_nxt = ERR;
                else
                    state_nxt = P_ADDR;
            end
            R_ADDR:  state_nxt = R_CHK;
            R_CHK:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort && state != IDLE)
            state_nxt = IDLE;
    end

    // Outputs are registered from the next state so each one is valid in the cycle of its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            b_q                  <= 32'h0;
            op_q                 <= 2'b00;
            run_cnt              <= 16'h0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            timeout              <= 1'b0;
            result               <= 32'h0;
            mem.cpu_run          <= 1'b0;
            mem.EntradaCalcu     <= 32'h0;
            mem.addressCalcu     <= 32'h0;
            mem.writeEnableCalcu <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == IDLE && state_nxt == WR_A) begin
                b_q     <= operand_b;
                op_q    <= opcode;
                timeout <= 1'b0;
            end
            if (state_nxt == ERR)
                timeout <= 1'b1;
            if (state == R_CHK && state_nxt == DONE)
                result <= mem.resultadoCalcu;

            if (state == CLR_ST)
                run_cnt <= 16'h0;
            else if ((state == P_ADDR || state == P_CHK) && run_cnt != 16'hFFFF)
                run_cnt <= run_cnt + 16'h1;

            busy                 <= (state_nxt != IDLE);
            done                 <= (state_nxt == DONE || state_nxt == ERR);
            mem.cpu_run          <= (state_nxt inside {P_ADDR, P_CHK, R_ADDR, R_CHK});
            mem.writeEnableCalcu <= (state_nxt inside {WR_A, WR_B, WR_OP, CLR_ST});

            // WR_A is only entered from IDLE, so operand A goes straight from the input.
            case (state_nxt)
                WR_A: begin
                    mem.addressCalcu <= ADDR_A;
                    mem.EntradaCalcu <= operand_a;
                end
                WR_B: begin
                    mem.addressCalcu <= ADDR_B;
                    mem.EntradaCalcu <= b_q;
                end
                WR_OP: begin
                    mem.addressCalcu <= ADDR_OP;
                    mem.EntradaCalcu <= {30'h0, op_q};
                end
                CLR_ST, P_ADDR, P_CHK: begin
                    mem.addressCalcu <= ADDR_ST;
                    mem.EntradaCalcu <= 32'h0;
                end
                R_ADDR, R_CHK: begin
                    mem.addressCalcu <= ADDR_RES;
                    mem.EntradaCalcu <= 32'h0;
                end
                default: begin
                    mem.addressCalcu <= 32'h0;
                    mem.EntradaCalcu <= 32'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: job timeline model plus memory/processor model, randomized jobs.
module tb_calc_sequencer;
    localparam int T = 8;
    localparam int K = (T + 2) / 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] operand_a = 32'h0;
    logic [31:0] operand_b = 32'h0;
    logic [1:0]  opcode = 2'b00;
    logic        busy, done, timeout;
    logic [31:0] result;

    calc_sequencer_if mem ();

    calc_sequencer #(.TIMEOUT(T)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .opcode   (opcode),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .result   (result),
        .mem      (mem)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // job model
    bit          chk_on = 0;
    bit          active = 0;
    bit          j_to = 0;
    int          cyc = 0;
    int          e_cyc = 0;
    int          ab_cyc = 0;
    int          jpolls = 0;
    int          done_cyc = -1;
    logic [31:0] ja = 0, jb = 0, jres = 0;
    logic [1:0]  jop = 0;
    logic [31:0] exp_result = 32'h0;
    logic        exp_timeout = 1'b0;

    // processor/memory: status turns nonzero from the P_ADDR of poll number jpolls onwards
    always @(posedge clk) begin
        if (mem.writeEnableCalcu)
            mem.resultadoCalcu <= 32'h0;
        else if (mem.addressCalcu == 32'h4C)
            mem.resultadoCalcu <= (active && jpolls > 0 && cyc >= 3 + 2 * jpolls) ? 32'h1 : 32'h0;
        else if (mem.addressCalcu == 32'h50)
            mem.resultadoCalcu <= jres;
        else
            mem.resultadoCalcu <= 32'h0;
    end

    logic [31:0] ea, ed;
    logic        eb, edn, er, ew;

    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            if (active) begin
                cyc++;
                eb  = 1'b1;
                edn = (cyc == e_cyc);
                er  = (cyc >= 5 && cyc <= e_cyc - 1);
                ew  = (cyc <= 4);
                ed  = 32'h0;
                ea  = 32'h4C;
                if (cyc == 1) begin ea = 32'h40; ed = ja; end
                else if (cyc == 2) begin ea = 32'h44; ed = jb; end
                else if (cyc == 3) begin ea = 32'h48; ed = {30'h0, jop}; end
                if (cyc == e_cyc) ea = 32'h0;
                else if (!j_to && cyc >= 5 && cyc >= e_cyc - 2) ea = 32'h50;
                if (cyc == e_cyc) begin
                    if (j_to) exp_timeout = 1'b1;
                    else exp_result = jres;
                end
            end else begin
                eb = 0; edn = 0; er = 0; ew = 0; ea = 0; ed = 0;
            end
            chk("busy", {31'h0, busy}, {31'h0, eb});
            chk("done", {31'h0, done}, {31'h0, edn});
            chk("cpu_run", {31'h0, mem.cpu_run}, {31'h0, er});
            chk("write_en", {31'h0, mem.writeEnableCalcu}, {31'h0, ew});
            chk("address", mem.addressCalcu, ea);
            chk("wdata", mem.EntradaCalcu, ed);
            chk("timeout", {31'h0, timeout}, {31'h0, exp_timeout});
            chk("result", result, exp_result);
            if (active && done === 1'b1) done_cyc = cyc;
            if (active && (cyc == e_cyc || cyc == ab_cyc)) active = 0;
        end
    end

    task automatic run_job(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                           input int polls, input logic [31:0] res, input int ab,
                           input bit stray, input int rst_at);
        int n;
        n = 0;
        while (active && n < 200) begin @(posedge clk); n++; end
        @(posedge clk); #1;
        operand_a = a; operand_b = b; opcode = op; start = 1'b1;
        ja = a; jb = b; jop = op; jres = res; jpolls = polls;
        if (polls >= 1 && polls <= K) begin j_to = 0; e_cyc = 7 + 2 * polls; end
        else begin j_to = 0; j_to = 1; e_cyc = 5 + 2 * K; end
        ab_cyc = ab;
        done_cyc = -1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; active = 1; exp_timeout = 1'b0;
        if (stray) begin
            start = 1'b1;
            operand_a = $urandom; operand_b = $urandom; opcode = 2'($urandom);
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (ab > 0) begin
            repeat (ab - 1) @(posedge clk);
            #1 abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
        end
        if (rst_at > 0) begin
            repeat (rst_at - 1) @(posedge clk);
            #2 rst_n = 1'b0; active = 0;
            #1;
            chk("rst_cpu_run", {31'h0, mem.cpu_run}, 32'h0);
            chk("rst_busy", {31'h0, busy}, 32'h0);
            chk("rst_done", {31'h0, done}, 32'h0);
            chk("rst_result", result, 32'h0);
            chk("rst_we", {31'h0, mem.writeEnableCalcu}, 32'h0);
            exp_result = 32'h0; exp_timeout = 1'b0;
            #4 rst_n = 1'b1;
        end
        n = 0;
        while (active && n < 200) begin @(posedge clk); n++; end
        if (active) begin
            tests++; fails++;
            $display("FAIL job_end: still active after %0d cycles", n);
            active = 0;
        end
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] prev;
        int          pl, e, ab;
        #3;
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_done", {31'h0, done}, 32'h0);
        chk("reset_timeout", {31'h0, timeout}, 32'h0);
        chk("reset_cpu_run", {31'h0, mem.cpu_run}, 32'h0);
        chk("reset_we", {31'h0, mem.writeEnableCalcu}, 32'h0);
        chk("reset_result", result, 32'h0);
        chk("reset_addr", mem.addressCalcu, 32'h0);
        chk("reset_wdata", mem.EntradaCalcu, 32'h0);
        #24 rst_n = 1'b1;
        chk_on = 1;
        repeat (20) @(posedge clk);

        run_job(32'h5, 32'h7, 2'b00, 3, 32'hC, 0, 0, 0);
        chk("nominal_done_cycle", done_cyc, 32'd13);
        chk("nominal_result", result, 32'hC);
        chk("nominal_timeout", {31'h0, timeout}, 32'h0);

        run_job($urandom, $urandom, 2'b11, 1, 32'hA5A5_0001, 0, 0, 0);
        chk("min_done_cycle", done_cyc, 32'd9);
        chk("min_result", result, 32'hA5A5_0001);

        run_job($urandom, $urandom, 2'b01, 0, 32'hDEAD_BEEF, 0, 0, 0);
        chk("timeout_done_cycle", done_cyc, 32'd15);
        chk("timeout_flag", {31'h0, timeout}, 32'h1);
        chk("timeout_result_kept", result, 32'hA5A5_0001);

        run_job(32'h11, 32'h22, 2'b10, 3, 32'h1234, 6, 0, 0);
        chk("abort_no_done", done_cyc, 32'hFFFF_FFFF);
        chk("abort_result_kept", result, 32'hA5A5_0001);
        chk("abort_timeout_cleared", {31'h0, timeout}, 32'h0);

        run_job(32'h33, 32'h44, 2'b01, 2, 32'h77, 0, 1, 0);
        chk("stray_done_cycle", done_cyc, 32'd11);
        chk("stray_result", result, 32'h77);

        run_job(32'h55, 32'h66, 2'b10, 4, 32'h99, 0, 0, 8);
        run_job(32'h9, 32'h3, 2'b11, 2, 32'h1B, 0, 0, 0);
        chk("post_reset_result", result, 32'h1B);

        for (int i = 0; i < 15; i++) begin
            pl = $urandom_range(0, 7);
            e = (pl >= 1 && pl <= K) ? 7 + 2 * pl : 5 + 2 * K;
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, e - 1) : 0;
            prev = result;
            run_job($urandom, $urandom, 2'($urandom), pl, $urandom, ab,
                    (ab == 0) && ($urandom_range(0, 2) == 0), 0);
            if (ab == 0 && pl >= 1 && pl <= K)
                chk("rand_done_cycle", done_cyc, 32'(7 + 2 * pl));
            else if (ab > 0)
                chk("rand_abort_result", result, prev);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end
endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Job sequencer for the calculator front end. Accepts one operation (two operands plus opcode) from the host, writes it into data memory through the processor's calculator memory port, and enables the processor. It then polls a status word until the program signals completion, reads back the result and reports it to the host. It sits between the host/keypad logic and the MicroProcessor's calculator memory port and run-enable, and is the only master of that port.

## Interface

Parameters:
- ADDR_A, 32'h40, word address of operand A
- ADDR_B, 32'h44, word address of operand B
- ADDR_OP, 32'h48, word address of opcode word
- ADDR_ST, 32'h4C, word address of status word (nonzero = program finished)
- ADDR_RES, 32'h50, word address of result word
- TIMEOUT, 1024, maximum run cycles before the job is declared failed (must be ≥ 2, < 2^16)

Ports:
- CLK  in  1  single clock, all state on rising edge
- RST_N  in  1  asynchronous, active-low reset
- start  in  1  request new job; sampled only in IDLE
- abort  in  1  synchronous cancel; highest priority after reset
- operand_a  in  32  operand A, captured on accepted start
- operand_b  in  32  operand B, captured on accepted start
- opcode  in  2  operation code, captured on accepted start, zero-extended to 32 bits when written
- busy  out  1  high from the cycle after accepted start until the DONE/ERR cycle, inclusive
- done  out  1  one-cycle pulse: job finished (success or timeout)
- timeout  out  1  valid with done; 1 = timeout. Holds until the next accepted start.
- result  out  32  last result read; holds until overwritten by the next successful job
- cpu_run  out  1  processor run enable
- EntradaCalcu  out  32  memory write data
- addressCalcu  out  32  memory address
- writeEnableCalcu  out  1  memory write strobe
- resultadoCalcu  in  32  memory read data, valid the cycle after addressCalcu is presented

## Operation

- States: IDLE, WR_A, WR_B, WR_OP, CLR_ST, P_ADDR, P_CHK, R_ADDR, R_CHK, DONE, ERR.
- IDLE: start=1 → capture operands and opcode, clear timeout → WR_A. No port activity; writeEnableCalcu=0.
- WR_A / WR_B / WR_OP: write the captured value to ADDR_A / ADDR_B / ADDR_OP (writeEnableCalcu=1, one cycle each). Then go to the next state in order.
- CLR_ST: write 32'h0 to ADDR_ST, clear the run counter → P_ADDR.
- P_ADDR: addressCalcu=ADDR_ST, no write → P_CHK.
- P_CHK: sample resultadoCalcu.
  - Nonzero → R_ADDR.
  - Zero and run counter ≥ TIMEOUT → ERR.
  - Otherwise → P_ADDR.
- R_ADDR: addressCalcu=ADDR_RES → R_CHK.
- R_CHK: register resultadoCalcu into result → DONE.
- DONE: done=1, timeout=0 → IDLE.
- ERR: done=1, timeout=1; result unchanged → IDLE.
- cpu_run is 1 exactly in P_ADDR, P_CHK, R_ADDR and R_CHK; 0 elsewhere. The processor is stopped before any host-visible completion.
- Run counter: 16-bit, cleared in CLR_ST, incremented each cycle in P_ADDR/P_CHK, saturates at all-ones.
- abort=1 in any non-IDLE state → IDLE next cycle with cpu_run=0, writeEnableCalcu=0, no done pulse, result unchanged. abort in IDLE has no effect, and abort wins over start.
- start while not in IDLE is ignored, and it is not queued.
- In every state other than the three WR_ and CLR_ST states, EntradaCalcu=0 and writeEnableCalcu=0. In IDLE, DONE and ERR, addressCalcu=0.

## Timing

- All outputs are registered, or decoded from registered state only. There is no combinational path from inputs to outputs.
- Reset (RST_N low, asynchronous): state=IDLE. busy, done, timeout, cpu_run and writeEnableCalcu are 0. result, EntradaCalcu and addressCalcu are 32'h0. The run counter is 0. Reset mid-job drops cpu_run immediately, with no completion.
- Start accepted at edge 0:
  - Cycles 1–4: the four writes.
  - Cycle 5: P_ADDR.
  - Cycle 6: P_CHK.
- Minimum latency: status found nonzero on the first poll gives R_ADDR in cycle 7, R_CHK in cycle 8, and done=1 in cycle 9 with result valid in cycle 9.
- Each additional poll adds 2 cycles.
- Timeout: the P_CHK that first sees counter ≥ TIMEOUT with status zero leads to ERR in the next cycle. The worst case is ≈ TIMEOUT + 8 cycles from start to done.
- A new start is accepted no earlier than the cycle after DONE/ERR, which is the IDLE cycle.

## Test plan

- Reset then idle: hold RST_N low mid-clock → all outputs 0 immediately. After release with start=0 for 20 cycles → no port writes, cpu_run=0.
- Nominal job: A=32'h5, B=32'h7, opcode=2'b00. Memory model returns status 1 on the third poll and result 32'hC → writes {40:5, 44:7, 48:0, 4C:0} in cycles 1–4, done in cycle 13, result=32'hC, timeout=0.
- Minimum latency: status nonzero on the first poll → done exactly at cycle 9. cpu_run is high in cycles 5–8 only.
- Timeout: TIMEOUT=8, status stays 0 → done=1 with timeout=1, result keeps its prior value, cpu_run low in the ERR cycle.
- Abort and ignored start: abort asserted during P_CHK → IDLE next cycle, no done, cpu_run=0. start pulsed during busy → no second job, operands not re-captured.
- Asynchronous reset mid-poll, then a new job → the second job completes normally with correct writes and result.
